pipe_stall_ctrl: RTL

//  Generates the write-enable (we) and synchronous clear (reset) inputs for the PC register and the four

---
 rtl/pipe_stall_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Hazard/stall controller for a 5-stage pipeline. Turns load-use, branch,
//   exception and I/D cache-miss events into write-enables and synchronous
//   clears for the PC register and the IF/ID, ID/EX, EX/MEM, MEM/WB flops.
//   Tracks outstanding misses in a 4-state FSM, counts stall cycles and
//   raises a sticky timeout when a miss stays outstanding too long.
// Ports
//   clk, reset          clock; synchronous active-high reset
//   load_use            ID instr depends on a load in EX (level)
//   branch_taken        branch/jump resolved taken in EX
//   exception           exception raised by instr in MEM
//   imiss / iready      I-cache miss / refill-done pulses
//   dmiss / dready      D-cache miss / refill-done pulses
//   pc_we               PC write enable
//   stage_we[3:0]       [0]=IF/ID [1]=ID/EX [2]=EX/MEM [3]=MEM/WB enables
//   stage_clr[3:0]      same indexing, synchronous clear (bubble insert)
//   state[1:0]          FSM state (debug)
//   stall_cnt[CNT_W]    saturating count of cycles with pc_we=0
//   timeout             sticky: miss outstanding for >= TIMEOUT cycles
module pipe_stall_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             exception,
  input  logic             imiss,
  input  logic             iready,
  input  logic             dmiss,
  input  logic             dready,
  output logic             pc_we,
  output logic [3:0]       stage_we,
  output logic [3:0]       stage_clr,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             timeout
);

  typedef enum logic [1:0] {RUN = 2'd0, IMISS = 2'd1, DMISS = 2'd2, DIMISS = 2'd3} st_e;

  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

  st_e              st_q, st_d;
  logic             kill_q, kill_d;
  logic [CNT_W-1:0] tcnt_q;
  logic             to_q;

  logic i_out, d_out, d_stall, i_stall, i_pend, kill_drop, redirect;

  // Miss outstanding according to the registered state.
  assign i_out = (st_q == IMISS) || (st_q == DIMISS);
  assign d_out = (st_q == DMISS) || (st_q == DIMISS);

  // A ready pulse releases its stall in the same cycle (refill data valid).
  assign d_stall = (d_out && !dready) || dmiss;
  assign i_stall = (i_out && !iready) || imiss;

  // I-miss still pending after this cycle: a fetch outstanding now whose
  // refill will arrive after a redirect, so it must be discarded.
  assign i_pend    = (i_out && !iready) || (imiss && st_q == RUN);
  assign kill_drop = kill_q && iready && i_out;
  assign redirect  = !reset && !d_stall && (exception || branch_taken);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) st_q <= RUN;
    else       st_q <= st_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      RUN: begin
        if (dmiss && imiss) st_d = DIMISS;
        else if (dmiss)     st_d = DMISS;
        else if (imiss)     st_d = IMISS;
      end
      IMISS: begin
        if (iready && dmiss) st_d = DMISS;
        else if (iready)     st_d = RUN;
        else if (dmiss)      st_d = DIMISS;
      end
      // IF is frozen behind the D-miss, so no new fetch can miss here.
      DMISS: begin
        if (dready) st_d = RUN;
      end
      DIMISS: begin
        if (dready && iready) st_d = RUN;
        else if (dready)      st_d = IMISS;
        else if (iready)      st_d = DMISS;
      end
      default: st_d = RUN;
    endcase
  end

  // ---------------- outputs (priority ordered) ----------------
  always_comb begin
    pc_we     = 1'b1;
    stage_we  = 4'hF;
    stage_clr = 4'h0;
    if (reset) begin
      pc_we     = 1'b0;
      stage_we  = 4'h0;
      stage_clr = 4'hF;
    end else if (d_stall) begin
      // Everything up to MEM is frozen and re-presented; WB gets a bubble.
      pc_we     = 1'b0;
      stage_we  = 4'b1000;
      stage_clr = 4'b1000;
    end else if (exception) begin
      stage_clr = 4'hF;
    end else if (branch_taken) begin
      stage_clr = 4'b0011;
    end else if (i_stall) begin
      pc_we     = 1'b0;
      stage_clr = 4'b0001;
    end else if (kill_drop) begin
      // Wrong-path refill: PC already holds the redirect target, so hold it
      // and drop the returned instruction.
      pc_we     = 1'b0;
      stage_clr = 4'b0001;
    end else if (load_use) begin
      pc_we     = 1'b0;
      stage_we  = 4'b1110;
      stage_clr = 4'b0010;
    end
  end

  // ---------------- kill flag ----------------
  always_comb begin
    kill_d = kill_q;
    if (i_out && !(st_d == IMISS || st_d == DIMISS)) kill_d = 1'b0;
    else if (redirect && i_pend)                     kill_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) kill_q <= 1'b0;
    else       kill_q <= kill_d;
  end

  // ---------------- stall and timeout counters ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      tcnt_q    <= '0;
      to_q      <= 1'b0;
    end else begin
      if (!pc_we && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (st_q == RUN) begin
        tcnt_q <= '0;
      end else begin
        if (tcnt_q != '1)     tcnt_q <= tcnt_q + 1'b1;
        // This non-RUN cycle brings the run length up to TIMEOUT.
        if (tcnt_q >= TO_M1)  to_q   <= 1'b1;
      end
    end
  end

  assign state   = st_q;
  assign timeout = to_q;

endmodule
